// File: rtl/rand_pkg.sv
// Shared types and constants for the bounded random draw block.
package rand_pkg;

   typedef enum logic [1:0] {
      EASY = 2'd0,
      MED  = 2'd1,
      HARD = 2'd2
   } level_t;

   typedef enum logic {
      IDLE = 1'b0,
      DRAW = 1'b1
   } draw_state_t;

   localparam logic [15:0] TAPS_DEFAULT = 16'hB400;

   // Level code 3 has no dedicated range and shares the hard limit.
   function automatic level_t decode_level(input logic [1:0] code);
      level_t lv;
      case (code)
         2'd0:    lv = EASY;
         2'd1:    lv = MED;
         default: lv = HARD;
      endcase
      return lv;
   endfunction

endpackage

// File: rtl/lfsr_core.sv
// Free-running Galois LFSR with seed load and freeze; the all-zero state is unreachable.
module lfsr_core
   import rand_pkg::*;
#(
   parameter int unsigned         WIDTH     = 16,
   parameter logic [WIDTH-1:0]    TAPS      = WIDTH'(TAPS_DEFAULT),
   parameter logic [WIDTH-1:0]    SEED_INIT = WIDTH'(1)
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             freeze,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] state
);

   localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
   localparam logic [WIDTH-1:0] RESET_STATE = (SEED_INIT == '0) ? ONE : SEED_INIT;

   logic [WIDTH-1:0] step;
   logic [WIDTH-1:0] seed_fixed;

   // Zero is a lock-up state, so both the step and a loaded seed are steered away from it.
   always_comb begin
      step       = (state >> 1) ^ (state[0] ? TAPS : '0);
      seed_fixed = seed;
      if (step == '0) begin
         step = ONE;
      end
      if (seed == '0) begin
         seed_fixed = ONE;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state <= RESET_STATE;
      end else if (seed_load) begin
         state <= seed_fixed;
      end else if (!freeze) begin
         state <= step;
      end
   end

endmodule

// File: rtl/rand_draw.sv
// Draws a value below a per-level limit from an LFSR by rejection sampling,
// folding the last rejected sample back into range so latency stays bounded.
module rand_draw
   import rand_pkg::*;
#(
   parameter int unsigned         WIDTH      = 16,
   parameter int unsigned         OUT_W      = 6,
   parameter logic [WIDTH-1:0]    TAPS       = WIDTH'(TAPS_DEFAULT),
   parameter logic [WIDTH-1:0]    SEED_INIT  = WIDTH'(1),
   parameter int unsigned         LIMIT_EASY = 10,
   parameter int unsigned         LIMIT_MED  = 24,
   parameter int unsigned         LIMIT_HARD = 40,
   parameter int unsigned         MAX_TRIES  = 4
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             freeze,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed,
   input  logic             req,
   input  logic [1:0]       level,
   output logic [OUT_W-1:0] rand_out,
   output logic             rand_valid,
   output logic             busy
);

   localparam int unsigned CMP_W     = OUT_W + 1;
   localparam int unsigned BITS_EASY = $clog2(LIMIT_EASY);
   localparam int unsigned BITS_MED  = $clog2(LIMIT_MED);
   localparam int unsigned BITS_HARD = $clog2(LIMIT_HARD);
   localparam int unsigned TRY_W     = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

   localparam logic [TRY_W-1:0] LAST_TRY  = TRY_W'(MAX_TRIES - 1);
   localparam logic [WIDTH-1:0] MASK_EASY = WIDTH'((64'd1 << BITS_EASY) - 64'd1);
   localparam logic [WIDTH-1:0] MASK_MED  = WIDTH'((64'd1 << BITS_MED) - 64'd1);
   localparam logic [WIDTH-1:0] MASK_HARD = WIDTH'((64'd1 << BITS_HARD) - 64'd1);
   localparam logic [CMP_W-1:0] LIM_EASY  = CMP_W'(LIMIT_EASY);
   localparam logic [CMP_W-1:0] LIM_MED   = CMP_W'(LIMIT_MED);
   localparam logic [CMP_W-1:0] LIM_HARD  = CMP_W'(LIMIT_HARD);

   // Parameter sanity: the sample must fit in both the LFSR and the output.
   if (LIMIT_EASY < 2 || LIMIT_MED < 2 || LIMIT_HARD < 2) begin : g_bad_limit
      $error("rand_draw: every limit must be at least 2");
   end
   if (BITS_HARD > OUT_W || BITS_MED > OUT_W || BITS_EASY > OUT_W) begin : g_bad_out_w
      $error("rand_draw: OUT_W too narrow for the configured limits");
   end
   if (BITS_HARD > WIDTH || BITS_MED > WIDTH || BITS_EASY > WIDTH) begin : g_bad_width
      $error("rand_draw: LFSR narrower than the sample width");
   end
   if (MAX_TRIES < 1) begin : g_bad_tries
      $error("rand_draw: MAX_TRIES must be at least 1");
   end

   logic [WIDTH-1:0] lfsr_state;
   draw_state_t      state_q;
   level_t           level_q;
   logic [TRY_W-1:0] tries_q;

   logic [WIDTH-1:0] mask_c;
   logic [CMP_W-1:0] lim_c;
   logic [CMP_W-1:0] raw_c;
   logic [CMP_W-1:0] fold_c;
   logic             accept_c;

   lfsr_core #(
      .WIDTH     (WIDTH),
      .TAPS      (TAPS),
      .SEED_INIT (SEED_INIT)
   ) u_lfsr (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .freeze    (freeze),
      .seed_load (seed_load),
      .seed      (seed),
      .state     (lfsr_state)
   );

   // Limit select and rejection compare for the latched level.
   always_comb begin
      mask_c = MASK_HARD;
      lim_c  = LIM_HARD;
      case (level_q)
         EASY: begin
            mask_c = MASK_EASY;
            lim_c  = LIM_EASY;
         end
         MED: begin
            mask_c = MASK_MED;
            lim_c  = LIM_MED;
         end
         default: begin
            mask_c = MASK_HARD;
            lim_c  = LIM_HARD;
         end
      endcase
      raw_c    = CMP_W'(lfsr_state & mask_c);
      accept_c = (raw_c < lim_c);
      // raw < 2*limit, so one subtraction always lands in range.
      fold_c   = raw_c - lim_c;
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q    <= IDLE;
         level_q    <= EASY;
         tries_q    <= '0;
         rand_out   <= '0;
         rand_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         rand_valid <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req) begin
                  level_q <= decode_level(level);
                  tries_q <= '0;
                  state_q <= DRAW;
                  busy    <= 1'b1;
               end
            end
            DRAW: begin
               if (accept_c) begin
                  rand_out   <= OUT_W'(raw_c);
                  rand_valid <= 1'b1;
                  state_q    <= IDLE;
                  busy       <= 1'b0;
               end else if (tries_q < LAST_TRY) begin
                  tries_q <= tries_q + TRY_W'(1);
               end else begin
                  rand_out   <= OUT_W'(fold_c);
                  rand_valid <= 1'b1;
                  state_q    <= IDLE;
                  busy       <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rand_draw.sv
// Self-checking bench for rand_draw: cycle model plus directed literal vectors.
module tb_rand_draw;

   localparam int          MAX_TRIES = 4;
   localparam logic [15:0] TAPS      = 16'hB400;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        freeze = 1'b0;
   logic        seed_load = 1'b0;
   logic [15:0] seed = 16'h0000;
   logic        req = 1'b0;
   logic [1:0]  level = 2'd0;
   logic [5:0]  rand_out;
   logic        rand_valid;
   logic        busy;

   int checks = 0;
   int failures = 0;

   rand_draw dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .freeze     (freeze),
      .seed_load  (seed_load),
      .seed       (seed),
      .req        (req),
      .level      (level),
      .rand_out   (rand_out),
      .rand_valid (rand_valid),
      .busy       (busy)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   // Behavioural model: LFSR as a plain sequence, draw as "count attempts, take modulo".
   logic [15:0] m_lfsr = 16'h0001;
   bit          m_pend = 0;
   int          m_try = 0;
   int          m_lim = 10;
   int          m_out = 0;
   bit          m_valid = 0;
   bit          m_busy = 0;
   bit          m_live = 0;

   function automatic int limit_of(input logic [1:0] lv);
      if (lv == 2'd0) return 10;
      if (lv == 2'd1) return 24;
      return 40;
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      logic [15:0] n;
      n = (s >> 1) ^ (s[0] ? TAPS : 16'h0000);
      return n;
   endfunction

   always @(posedge Clk) begin
      int raw;
      if (!Reset_n) begin
         m_lfsr  = 16'h0001;
         m_pend  = 0;
         m_try   = 0;
         m_out   = 0;
         m_valid = 0;
         m_busy  = 0;
      end else begin
         m_valid = 0;
         if (m_pend) begin
            raw = int'(m_lfsr) % (1 << $clog2(m_lim));
            if (raw < m_lim) begin
               m_out = raw;  m_valid = 1;  m_pend = 0;
            end else if (m_try == MAX_TRIES - 1) begin
               m_out = raw - m_lim;  m_valid = 1;  m_pend = 0;
            end else begin
               m_try++;
            end
         end else if (req) begin
            m_pend = 1;
            m_try  = 0;
            m_lim  = limit_of(level);
         end
         m_busy = m_pend;
         if (seed_load) m_lfsr = (seed == 16'h0000) ? 16'h0001 : seed;
         else if (!freeze) m_lfsr = lfsr_next(m_lfsr);
      end
      m_live = 1;
   end

   always @(negedge Clk) begin
      if (m_live) begin
         check("model_lfsr", int'(dut.lfsr_state), int'(m_lfsr));
         check("model_out", int'(rand_out), m_out);
         check("model_valid", int'(rand_valid), int'(m_valid));
         check("model_busy", int'(busy), int'(m_busy));
      end
   end

   // Issue one request and measure edges from the request edge to rand_valid.
   task automatic draw(input logic [1:0] lv, input int exp_out, input int exp_edges,
                       input bit pulse_mid, input string name);
      int n;
      bit seen;
      n = 0;
      seen = 0;
      level = lv;
      req = 1'b1;
      while (!seen && n < 10) begin
         tick();
         n++;
         req = pulse_mid && (n == 2);
         if (rand_valid) seen = 1;
      end
      req = 1'b0;
      check({name, "_seen"}, int'(seen), 1);
      check({name, "_edges"}, n, exp_edges);
      check({name, "_out"}, int'(rand_out), exp_out);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int extra;
      int n;
      bit seen;

      repeat (2) @(negedge Clk);
      check("rst_lfsr", int'(dut.lfsr_state), 16'h0001);
      check("rst_out", int'(rand_out), 0);
      check("rst_valid", int'(rand_valid), 0);
      check("rst_busy", int'(busy), 0);

      Reset_n = 1'b1;
      tick();  check("seq_1", int'(dut.lfsr_state), 16'hB400);
      tick();  check("seq_2", int'(dut.lfsr_state), 16'h5A00);
      tick();  check("seq_3", int'(dut.lfsr_state), 16'h2D00);

      seed_load = 1'b1;  seed = 16'h0000;
      tick();
      seed_load = 1'b0;
      check("seed_zero", int'(dut.lfsr_state), 16'h0001);

      // Frozen LFSR: one-shot accept, then a back-to-back repeat.
      freeze = 1'b1;  seed_load = 1'b1;  seed = 16'h0017;
      tick();
      seed_load = 1'b0;
      draw(2'd1, 23, 2, 1'b0, "med_accept");
      draw(2'd1, 23, 2, 1'b0, "med_b2b");

      seed_load = 1'b1;  seed = 16'h005A;
      tick();
      seed_load = 1'b0;
      draw(2'd0, 0, 5, 1'b0, "easy_fallback");

      seed_load = 1'b1;  seed = 16'h003F;
      tick();
      seed_load = 1'b0;
      draw(2'd3, 23, 5, 1'b1, "lvl3_fallback");
      extra = 0;
      repeat (6) begin
         tick();
         if (rand_valid) extra++;
      end
      check("lvl3_single_valid", extra, 0);

      // Reset in the middle of a long draw.
      seed_load = 1'b1;  seed = 16'h005A;
      tick();
      seed_load = 1'b0;
      level = 2'd0;  req = 1'b1;
      tick();
      req = 1'b0;
      tick();
      check("mid_busy", int'(busy), 1);
      Reset_n = 1'b0;
      tick();
      check("mid_rst_valid", int'(rand_valid), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_out", int'(rand_out), 0);
      check("mid_rst_lfsr", int'(dut.lfsr_state), 16'h0001);
      Reset_n = 1'b1;
      freeze = 1'b0;

      // Free-running draws; seed_load and freeze disturb some of them mid-flight.
      for (int i = 0; i < 16; i++) begin
         level = 2'(i % 4);
         req = 1'b1;
         n = 0;
         seen = 0;
         while (!seen && n < 8) begin
            tick();
            n++;
            req = 1'b0;
            seed_load = (i == 3 && n == 1);
            seed = 16'h1234;
            freeze = (i == 6 && n < 3);
            if (rand_valid) seen = 1;
         end
         seed_load = 1'b0;
         freeze = 1'b0;
         check("run_seen", int'(seen), 1);
         repeat (i % 3) tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rand_draw.md
RAND_DRAW -- requirements
Module: rand_draw

Interface
REQ-001 Param WIDTH, default 16, LFSR state width.
REQ-002 Param OUT_W, default 6, width of rand_out.
REQ-003 Param TAPS, default 16'hB400, Galois feedback mask.
REQ-004 Param SEED_INIT, default 16'h0001, reset state of the LFSR.
REQ-005 Params LIMIT_EASY / LIMIT_MED / LIMIT_HARD, defaults 10 / 24 / 40, exclusive upper bound per level.
REQ-006 Param MAX_TRIES, default 4, draw attempts before fallback.
REQ-007 Clk  in  1  sole clock; all logic on posedge.
REQ-008 Reset_n  in  1  synchronous, active-low reset.
REQ-009 freeze  in  1  high: LFSR holds its state.
REQ-010 seed_load  in  1  high: LFSR loads seed on next edge.
REQ-011 seed  in  WIDTH  seed value.
REQ-012 req  in  1  draw request, sampled only when idle.
REQ-013 level  in  2  0=easy, 1=medium, 2=hard, 3=hard.
REQ-014 rand_out  out  OUT_W  drawn value, held until next valid.
REQ-015 rand_valid  out  1  one-cycle pulse, rand_out new.
REQ-016 busy  out  1  high while a draw is in progress (state DRAW).

Function
REQ-017 The LFSR SHALL advance each edge with freeze=0: next = (s>>1) ^ (s[0] ? TAPS : 0).
REQ-018 Priority SHALL be seed_load > freeze > advance; seed 0 SHALL load as 1; the LFSR SHALL never hold 0.
REQ-019 The LFSR SHALL run independently of draws.
REQ-020 The FSM SHALL have states IDLE and DRAW.
REQ-021 IDLE: when req=1, the block SHALL latch level, clear tries and enter DRAW; busy=1 from the next cycle.
REQ-022 req SHALL be ignored while in DRAW; no queuing.
REQ-023 Per level L, the bit count SHALL be b = clog2(L); raw = LFSR[b-1:0] sampled in each DRAW cycle.
REQ-024 If raw < L, the block SHALL register rand_out=raw and rand_valid=1, then return to IDLE.
REQ-025 If raw >= L and tries < MAX_TRIES-1, it SHALL increment tries and stay in DRAW.
REQ-026 If raw >= L on attempt MAX_TRIES, it SHALL output raw-L (always < L, since raw < 2L), then go to IDLE.
REQ-027 Latency SHALL be min 2 edges from the req edge to rand_valid high and max 1+MAX_TRIES edges.
REQ-028 A power-of-two L SHALL never reject.
REQ-029 A seed_load or freeze during DRAW SHALL NOT abort the draw; sampling uses the resulting LFSR state.
REQ-030 req asserted in the same cycle rand_valid is high SHALL be accepted, giving back-to-back draws.
REQ-031 rand_out SHALL be zero-extended to OUT_W; elaboration SHALL fail if clog2(LIMIT_HARD) > OUT_W or any limit < 2.

Reset
REQ-032 On Reset_n=0 at an edge: LFSR=SEED_INIT (0 mapped to 1), FSM=IDLE, tries=0, rand_out=0, rand_valid=0, busy=0.
REQ-033 Reset SHALL take priority over seed_load, req and an in-flight draw; the draw is discarded with no rand_valid.

Structure
REQ-034 Package rand_pkg SHALL hold the level_t enum (EASY, MED, HARD), the draw_state_t enum (IDLE, DRAW) and the default TAPS constant.
REQ-035 The LFSR SHALL be sub-module lfsr_core (params WIDTH, TAPS, SEED_INIT; ports Clk, Reset_n, freeze, seed_load, seed, state).
REQ-036 rand_draw SHALL hold the FSM, limit select, compare and fallback logic.

Verification
REQ-037 Reset, then free-run with freeze=0 -> LFSR sequence 0x0001, 0xB400, 0x5A00, 0x2D00.
REQ-038 seed_load, seed=0x0000 -> next-cycle LFSR state 0x0001.
REQ-039 freeze=1, seed 0x0017, req, level=1 -> rand_valid 2 edges after req, rand_out=23.
REQ-040 freeze=1, seed 0x005A, req, level=0 -> 4 rejects of raw 10, rand_valid at edge 5, rand_out=0.
REQ-041 freeze=1, seed 0x003F, level=3 -> treated as hard, fallback rand_out=23 after MAX_TRIES; req pulsed during busy is ignored (exactly one valid).
REQ-042 Reset_n low mid-DRAW -> no rand_valid, busy=0, rand_out=0, LFSR=SEED_INIT next cycle.
